usb_uart_bridge: RTL

// - Buffered adapter between the picosoc memory-mapped UART registers and the usb_uart byte streams.
// - It sits between the CPU bus and the usb_uart core, in place of the current per-access handshake.
// - Each direction has its own FIFO: TX (CPU -> uart_in_*) and RX (uart_out_* -> CPU).
// - CPU reads never stall; CPU writes stall only while the TX FIFO is full.
// - A status word exposes the fill levels to firmware.

---
 rtl/usb_uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/usb_uart_bridge.sv | 95 +++++++++
 3 files changed

// File: rtl/usb_uart_pkg.sv
// Shared constants for the usb_uart bridge: status word bit positions and
// the value the data register reads back when the RX FIFO holds nothing.
package usb_uart_pkg;

   // Status word: [7:0] rx_count, [15:8] tx_count, flags in [19:16].
   // A freshly reset bridge reads 32'h0005_0000 (tx_empty and rx_empty set).
   localparam int STAT_RX_CNT_LSB = 0;
   localparam int STAT_TX_CNT_LSB = 8;
   localparam int STAT_TX_EMPTY   = 16;
   localparam int STAT_TX_FULL    = 17;
   localparam int STAT_RX_EMPTY   = 18;
   localparam int STAT_RX_FULL    = 19;

   localparam logic [31:0] UART_EMPTY_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with register-array storage and a fill count.
// Ports: clk_48mhz, reset (sync, high), push/push_data, pop, head, count,
// full, empty. A push into a full FIFO and a pop from an empty one are ignored.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_48mhz,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_push;
   logic                  w_pop;

   assign full   = (r_count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign head   = r_mem[r_rd_ptr];

   // Full refuses the push even if a pop frees a slot this cycle;
   // empty ignores the pop even if a push arrives this cycle.
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge clk_48mhz) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
            2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/usb_uart_bridge.sv
// Buffered bridge between the picosoc UART registers and usb_uart streams.
// Ports: CPU data/status registers (reg_*), TX stream (uart_in_*), RX stream (uart_out_*).
module usb_uart_bridge
   import usb_uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk_48mhz,
   input  logic        reset,
   input  logic        reg_dat_we,
   input  logic        reg_dat_re,
   input  logic [31:0] reg_dat_di,
   output logic [31:0] reg_dat_do,
   output logic        reg_dat_wait,
   output logic [31:0] reg_stat_do,
   output logic [7:0]  uart_in_data,
   output logic        uart_in_valid,
   input  logic        uart_in_ready,
   input  logic [7:0]  uart_out_data,
   input  logic        uart_out_valid,
   output logic        uart_out_ready
);

   logic [7:0]          w_tx_head;
   logic [DEPTH_LOG2:0] w_tx_count;
   logic                w_tx_full;
   logic                w_tx_empty;
   logic                w_tx_push;
   logic                w_tx_pop;

   logic [7:0]          w_rx_head;
   logic [DEPTH_LOG2:0] w_rx_count;
   logic                w_rx_full;
   logic                w_rx_empty;
   logic                w_rx_push;
   logic                w_rx_pop;

   logic                w_unused_di;

   // Only the low byte of the CPU write data carries a character.
   assign w_unused_di    = ^reg_dat_di[31:8];

   assign reg_dat_wait   = reg_dat_we & w_tx_full;
   assign w_tx_push      = reg_dat_we & ~w_tx_full;
   assign uart_in_valid  = ~w_tx_empty;
   assign uart_in_data   = w_tx_head;
   assign w_tx_pop       = uart_in_valid & uart_in_ready;

   assign uart_out_ready = ~w_rx_full & ~reset;
   assign w_rx_push      = uart_out_valid & uart_out_ready;
   assign w_rx_pop       = reg_dat_re & ~w_rx_empty;

   assign reg_dat_do = w_rx_empty ? UART_EMPTY_WORD : {24'h0, w_rx_head};

   always_comb begin
      reg_stat_do = '0;
      reg_stat_do[STAT_RX_CNT_LSB +: 8] = 8'(w_rx_count);
      reg_stat_do[STAT_TX_CNT_LSB +: 8] = 8'(w_tx_count);
      reg_stat_do[STAT_TX_EMPTY]        = w_tx_empty;
      reg_stat_do[STAT_TX_FULL]         = w_tx_full;
      reg_stat_do[STAT_RX_EMPTY]        = w_rx_empty;
      reg_stat_do[STAT_RX_FULL]         = w_rx_full;
   end

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) tx_fifo (
      .clk_48mhz (clk_48mhz),
      .reset     (reset),
      .push      (w_tx_push),
      .push_data (reg_dat_di[7:0]),
      .pop       (w_tx_pop),
      .head      (w_tx_head),
      .count     (w_tx_count),
      .full      (w_tx_full),
      .empty     (w_tx_empty)
   );

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) rx_fifo (
      .clk_48mhz (clk_48mhz),
      .reset     (reset),
      .push      (w_rx_push),
      .push_data (uart_out_data),
      .pop       (w_rx_pop),
      .head      (w_rx_head),
      .count     (w_rx_count),
      .full      (w_rx_full),
      .empty     (w_rx_empty)
   );

endmodule
